// File: rtl/retro_catc_pkg.sv
// Shared types for the CATC memory-stall slice.
//   catc_stall_state_t : access FSM states (idle, request issued, waiting for ack)
//   LatBits            : width of the capture-to-completion latency counter
package retro_catc_pkg;

    typedef enum logic [1:0] {
        CATC_IDLE  = 2'd0,
        CATC_ISSUE = 2'd1,
        CATC_WAIT  = 2'd2
    } catc_stall_state_t;

    localparam int LatBits = 16;

endpackage

// File: rtl/retro_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   Clk, Reset : clock and synchronous active-high reset
//   Clear      : zero the count (takes priority over Inc)
//   Inc        : add one unless already all-ones
//   Count      : current value
module retro_sat_counter #(
    parameter int Width = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Inc,
    output logic [Width-1:0] Count
);

    // Hold at all-ones once reached so statistics never wrap.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Count <= '0;
        end else if (Clear) begin
            Count <= '0;
        end else if (Inc && (Count != {Width{1'b1}})) begin
            Count <= Count + 1'b1;
        end
    end

endmodule

// File: rtl/retro_catc_mem_stall.sv
// Upstream stall generator for the CATC clock-enable controller.
// Captures a core access on a core tick, runs a valid/ready + ack handshake
// with slow memory and holds Delay high until the access completes.
//   Clk, Reset             : clock, synchronous active-high reset
//   CoreCe/CoreReq/CoreWe  : core tick, access request, write select
//   CoreAddr/CoreWData     : access address and write data
//   CoreRData              : last completed read data
//   Delay                  : high while an access is outstanding
//   MemReq/MemReady        : memory request handshake
//   MemWe/MemAddr/MemWData : latched access sent to memory
//   MemAck/MemRData        : completion strobe and read data
//   ClearStats             : clears StallCycles, MaxLatency, Timeout, ProtoErr
//   StallCycles            : saturating count of stalled cycles
//   MaxLatency             : worst capture-to-completion latency
//   Timeout/ProtoErr       : sticky error flags
module retro_catc_mem_stall
    import retro_catc_pkg::*;
#(
    parameter int                   AddrBits    = 16,
    parameter int                   DataBits    = 8,
    parameter int                   TimeoutCyc  = 4096,
    parameter logic [DataBits-1:0]  OpenBusData = 8'hFF,
    parameter int                   StatBits    = 24
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                CoreCe,
    input  logic                CoreReq,
    input  logic                CoreWe,
    input  logic [AddrBits-1:0] CoreAddr,
    input  logic [DataBits-1:0] CoreWData,
    output logic [DataBits-1:0] CoreRData,
    output logic                Delay,
    output logic                MemReq,
    input  logic                MemReady,
    output logic                MemWe,
    output logic [AddrBits-1:0] MemAddr,
    output logic [DataBits-1:0] MemWData,
    input  logic                MemAck,
    input  logic [DataBits-1:0] MemRData,
    input  logic                ClearStats,
    output logic [StatBits-1:0] StallCycles,
    output logic [15:0]         MaxLatency,
    output logic                Timeout,
    output logic                ProtoErr
);

    localparam int WaitBits = (TimeoutCyc > 2) ? $clog2(TimeoutCyc) : 1;
    localparam logic [WaitBits-1:0] WaitLast = WaitBits'(TimeoutCyc - 1);

    catc_stall_state_t state, nextState;
    logic                capture, complete, timeoutHit, protoHit;
    logic                latClear, latInc;
    logic                ackMask;
    logic [WaitBits-1:0] waitCnt;
    logic [LatBits-1:0]  lat;

    assign Delay  = (state != CATC_IDLE);
    assign MemReq = (state == CATC_ISSUE);

    // A tick request outside IDLE is illegal under CATC gating; an ack with
    // no access outstanding is stray unless it belongs to an access that a
    // reset cut short (ackMask covers that window until the next capture).
    assign protoHit = (CoreCe && CoreReq && (state != CATC_IDLE)) ||
                      (MemAck && (state == CATC_IDLE) && !ackMask);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= CATC_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus one-cycle event strobes; an ack on the last WAIT cycle
    // beats the timeout.
    always_comb begin
        nextState  = state;
        capture    = 1'b0;
        complete   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            CATC_IDLE: begin
                if (CoreCe && CoreReq) begin
                    capture   = 1'b1;
                    nextState = CATC_ISSUE;
                end
            end
            CATC_ISSUE: begin
                if (MemReady && MemAck) begin
                    complete  = 1'b1;
                    nextState = CATC_IDLE;
                end else if (MemReady) begin
                    nextState = CATC_WAIT;
                end
            end
            CATC_WAIT: begin
                if (MemAck) begin
                    complete  = 1'b1;
                    nextState = CATC_IDLE;
                end else if (waitCnt == WaitLast) begin
                    timeoutHit = 1'b1;
                    nextState  = CATC_IDLE;
                end
            end
            default: nextState = CATC_IDLE;
        endcase
    end

    // Counts WAIT cycles; held at zero elsewhere so it restarts on every entry.
    always_ff @(posedge Clk) begin
        if (Reset || (state != CATC_WAIT)) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    // Latency reads 1 in the first stalled cycle; it is zeroed when an access
    // ends so a capture on the very next cycle starts from a clean count.
    assign latInc   = capture || (state != CATC_IDLE);
    assign latClear = ((state == CATC_IDLE) && !capture) || complete || timeoutHit;

    retro_sat_counter #(.Width(LatBits)) latCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .Clear (latClear),
        .Inc   (latInc),
        .Count (lat)
    );

    retro_sat_counter #(.Width(StatBits)) stallCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .Clear (ClearStats),
        .Inc   (Delay),
        .Count (StallCycles)
    );

    // Access latches, returned read data and sticky statistics. A timeout is
    // a forced completion, so it also feeds the worst-case latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            MemWe      <= 1'b0;
            MemAddr    <= '0;
            MemWData   <= '0;
            CoreRData  <= '0;
            MaxLatency <= '0;
            Timeout    <= 1'b0;
            ProtoErr   <= 1'b0;
            ackMask    <= 1'b1;
        end else begin
            if (capture) begin
                MemWe    <= CoreWe;
                MemAddr  <= CoreAddr;
                MemWData <= CoreWData;
                ackMask  <= 1'b0;
            end
            if (complete && !MemWe) begin
                CoreRData <= MemRData;
            end else if (timeoutHit && !MemWe) begin
                CoreRData <= OpenBusData;
            end
            if (ClearStats) begin
                MaxLatency <= '0;
                Timeout    <= 1'b0;
                ProtoErr   <= 1'b0;
            end else begin
                if ((complete || timeoutHit) && (lat > MaxLatency)) begin
                    MaxLatency <= lat;
                end
                if (timeoutHit) begin
                    Timeout <= 1'b1;
                end
                if (protoHit) begin
                    ProtoErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_retro_catc_mem_stall.sv
// Self-checking bench for retro_catc_mem_stall (TimeoutCyc=16, StatBits=4).
// A transaction-level reference model tracks each access (outstanding or not,
// accepted by memory or not, elapsed cycles) and predicts every output.
module tb_retro_catc_mem_stall;

    localparam int TimeoutCyc = 16;
    localparam int StatMax    = 15;

    logic        Clk = 1'b0;
    logic        Reset, CoreCe, CoreReq, CoreWe, MemReady, MemAck, ClearStats;
    logic [15:0] CoreAddr;
    logic [7:0]  CoreWData, MemRData;
    logic [7:0]  CoreRData, MemWData;
    logic        Delay, MemReq, MemWe, Timeout, ProtoErr;
    logic [15:0] MemAddr, MaxLatency;
    logic [3:0]  StallCycles;

    int checks = 0;
    int fails  = 0;
    int delayCount;

    // Reference model state.
    logic        mBusy, mAccepted, mWe, mTimeout, mProto, mAckMask;
    logic [15:0] mAddr;
    logic [7:0]  mWData, mRData;
    int          mLat, mWait, mStall, mMaxLat;

    retro_catc_mem_stall #(
        .AddrBits(16), .DataBits(8), .TimeoutCyc(TimeoutCyc),
        .OpenBusData(8'hFF), .StatBits(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .CoreCe(CoreCe), .CoreReq(CoreReq),
        .CoreWe(CoreWe), .CoreAddr(CoreAddr), .CoreWData(CoreWData),
        .CoreRData(CoreRData), .Delay(Delay), .MemReq(MemReq),
        .MemReady(MemReady), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData),
        .ClearStats(ClearStats), .StallCycles(StallCycles),
        .MaxLatency(MaxLatency), .Timeout(Timeout), .ProtoErr(ProtoErr)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic modelStep();
        logic wasBusy, finish, setTo, setPe;
        wasBusy = mBusy;
        finish  = 1'b0;
        setTo   = 1'b0;
        if (Reset) begin
            mBusy = 0; mAccepted = 0; mWe = 0; mAddr = 0; mWData = 0; mRData = 0;
            mLat = 0; mWait = 0; mStall = 0; mMaxLat = 0;
            mTimeout = 0; mProto = 0; mAckMask = 1;
            return;
        end
        setPe = (CoreCe && CoreReq && wasBusy) || (MemAck && !wasBusy && !mAckMask);
        if (ClearStats) mStall = 0;
        else if (wasBusy && mStall < StatMax) mStall++;
        if (!wasBusy) begin
            if (CoreCe && CoreReq) begin
                mBusy = 1; mAccepted = 0; mLat = 1; mAckMask = 0;
                mWe = CoreWe; mAddr = CoreAddr; mWData = CoreWData;
            end
        end else if (!mAccepted) begin
            if (MemReady && MemAck) begin
                finish = 1;
                if (!mWe) mRData = MemRData;
            end else if (MemReady) begin
                mAccepted = 1; mWait = 0;
            end
        end else begin
            if (MemAck) begin
                finish = 1;
                if (!mWe) mRData = MemRData;
            end else if (mWait == TimeoutCyc - 1) begin
                finish = 1; setTo = 1;
                if (!mWe) mRData = 8'hFF;
            end else begin
                mWait++;
            end
        end
        if (ClearStats) begin
            mMaxLat = 0; mTimeout = 0; mProto = 0;
        end else begin
            if (finish && mLat > mMaxLat) mMaxLat = mLat;
            if (setTo) mTimeout = 1;
            if (setPe) mProto = 1;
        end
        if (wasBusy) begin
            if (finish) mBusy = 0;
            else if (mLat < 16'hFFFF) mLat++;
        end
    endtask

    task automatic compareAll();
        checkOutput("Delay",       32'(Delay),       32'(mBusy));
        checkOutput("MemReq",      32'(MemReq),      32'(mBusy && !mAccepted));
        checkOutput("CoreRData",   32'(CoreRData),   32'(mRData));
        checkOutput("MemWe",       32'(MemWe),       32'(mWe));
        checkOutput("MemAddr",     32'(MemAddr),     32'(mAddr));
        checkOutput("MemWData",    32'(MemWData),    32'(mWData));
        checkOutput("StallCycles", 32'(StallCycles), 32'(mStall));
        checkOutput("MaxLatency",  32'(MaxLatency),  32'(mMaxLat));
        checkOutput("Timeout",     32'(Timeout),     32'(mTimeout));
        checkOutput("ProtoErr",    32'(ProtoErr),    32'(mProto));
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic applyStimulus(input logic ce, input logic req, input logic we,
                                 input logic [15:0] addr, input logic [7:0] wd,
                                 input logic rdy, input logic ack, input logic [7:0] rd,
                                 input logic clr, input logic rst);
        CoreCe = ce; CoreReq = req; CoreWe = we; CoreAddr = addr; CoreWData = wd;
        MemReady = rdy; MemAck = ack; MemRData = rd; ClearStats = clr; Reset = rst;
        @(posedge Clk);
        modelStep();
        #1;
        if (Delay === 1'b1) delayCount++;
        compareAll();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 0);
    endtask

    task automatic resetCycles();
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 1);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 1);
        idleCycle();
        delayCount = 0;
    endtask

    initial begin
        logic       lastCe, ce;
        int         ackPct;
        resetCycles();

        // Zero-wait read
        applyStimulus(1, 1, 0, 16'h1234, 8'h00, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 8'h00, 1, 1, 8'h5A, 0, 0);
        idleCycle();
        checkOutput("zw_delay_cycles", 32'(delayCount), 32'd1);
        checkOutput("zw_rdata",        32'(CoreRData),  32'h5A);
        checkOutput("zw_maxlat",       32'(MaxLatency), 32'd1);

        // Slow write: ready on 3rd stalled cycle, ack 10 cycles later
        resetCycles();
        applyStimulus(1, 1, 1, 16'h2000, 8'h33, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 0, 8'h0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 0);
            checkOutput("wr_addr_stable", 32'(MemAddr), 32'h2000);
        end
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 1, 8'hEE, 0, 0);
        idleCycle();
        checkOutput("wr_delay_cycles", 32'(delayCount),  32'd13);
        checkOutput("wr_stall",        32'(StallCycles), 32'd13);
        checkOutput("wr_rdata_kept",   32'(CoreRData),   32'h00);
        checkOutput("wr_wdata",        32'(MemWData),    32'h33);

        // Read that never gets acked
        resetCycles();
        applyStimulus(1, 1, 0, 16'h0042, 8'h00, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 0, 8'h0, 0, 0);
        for (int i = 0; i < TimeoutCyc; i++) applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 0);
        checkOutput("to_delay_cycles", 32'(delayCount), 32'(TimeoutCyc + 1));
        checkOutput("to_idle",         32'(Delay),      32'd0);
        checkOutput("to_rdata",        32'(CoreRData),  32'hFF);
        checkOutput("to_flag",         32'(Timeout),    32'd1);
        checkOutput("to_proto_before", 32'(ProtoErr),   32'd0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 1, 8'h77, 0, 0);
        checkOutput("to_stray_ack",    32'(ProtoErr),   32'd1);

        // Illegal request while waiting
        resetCycles();
        applyStimulus(1, 1, 0, 16'h1111, 8'h00, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 0, 8'h0, 0, 0);
        applyStimulus(1, 1, 1, 16'hBEEF, 8'hAB, 0, 0, 8'h0, 0, 0);
        checkOutput("pe_addr_kept", 32'(MemAddr),  32'h1111);
        checkOutput("pe_we_kept",   32'(MemWe),    32'd0);
        checkOutput("pe_flag",      32'(ProtoErr), 32'd1);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 1, 8'hC3, 0, 0);

        // Reset while waiting, late ack
        resetCycles();
        applyStimulus(1, 1, 0, 16'h3333, 8'h00, 0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 0, 8'h0, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 1);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 1, 8'h99, 0, 0);
        checkOutput("rst_delay", 32'(Delay),     32'd0);
        checkOutput("rst_rdata", 32'(CoreRData), 32'h00);
        checkOutput("rst_proto", 32'(ProtoErr),  32'd0);

        // Stall counter saturation and clear-while-stalled
        resetCycles();
        applyStimulus(1, 1, 0, 16'h4444, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 19; i++) applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 0, 0);
        checkOutput("sat_stall", 32'(StallCycles), 32'hF);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 8'h0, 1, 0);
        checkOutput("clr_stall", 32'(StallCycles), 32'h0);
        applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 1, 8'h21, 0, 0);

        // Random traffic, ack likelihood varied per segment
        lastCe = 1'b0;
        ackPct = 30;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: ackPct = 3;
                    1: ackPct = 30;
                    default: ackPct = 75;
                endcase
            end
            ce = !lastCe && ($urandom_range(0, 2) == 0);
            lastCe = ce;
            applyStimulus(ce, ($urandom_range(0, 3) != 0), 1'($urandom),
                          16'($urandom), 8'($urandom),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < ackPct),
                          8'($urandom), ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 499) == 0));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
